// File: rtl/run_control_pkg.sv
// run_control_pkg: FSM state encoding and default constants shared by the
// front-panel run/step controller and its input conditioners.
package run_control_pkg;

    typedef enum logic [1:0] {
        RC_RUN       = 2'd0,
        RC_HALTED    = 2'd1,
        RC_STEP_LOW  = 2'd2,
        RC_STEP_HIGH = 2'd3
    } rc_state_e;

    localparam int RC_DEBOUNCE_DEFAULT      = 500000;
    localparam int RC_RESET_STRETCH_DEFAULT = 16;

endpackage

// File: rtl/run_control_sync_debounce.sv
// sync_debounce: multi-flop synchronizer followed by a counter debouncer for
// one raw board input; the accepted value flips after CYCLES stable cycles.
module sync_debounce
    import run_control_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int CYCLES = RC_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_db
);

    localparam int CW = CYCLES > 1 ? $clog2(CYCLES) : 1;

    logic [STAGES-1:0] r_sync;
    logic [CW-1:0]     r_cnt;
    logic              w_synced;

    assign w_synced = r_sync[STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_cnt  <= '0;
            o_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_raw};
            if (w_synced == o_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(CYCLES - 1)) begin
                o_db  <= w_synced;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_control.sv
// run_control: debounced front-panel run/step controller driving the divider's
// reset/setFreq/halt; RUN_CONTROL_STEP_COUNT_EN adds a 16-bit step_count output.
module run_control
    import run_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = RC_DEBOUNCE_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int RESET_STRETCH   = RC_RESET_STRETCH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_reset_raw,
    input  logic        btn_step_raw,
    input  logic        sw_mode_raw,
    input  logic        sw_fast_raw,
    input  logic        cpu_halt,
    input  logic        reg1Hz,
    output logic        sys_reset,
    output logic        setFreq,
    output logic        halt,
    output logic        step_busy
`ifdef RUN_CONTROL_STEP_COUNT_EN
    ,
    output logic [15:0] step_count
`endif
);

    localparam int SW = RESET_STRETCH > 0 ? $clog2(RESET_STRETCH + 1) : 1;

    logic          w_db_rst, w_db_step, w_db_mode, w_db_fast;
    logic          w_step_pulse;
    logic          r_rst_prev, r_step_prev, r_latch;
    logic [SW-1:0] r_stretch, w_stretch_nxt;
    rc_state_e     r_state, w_state_nxt;

    sync_debounce #(.STAGES(SYNC_STAGES), .CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk(clk), .reset(reset), .i_raw(btn_reset_raw), .o_db(w_db_rst)
    );
    sync_debounce #(.STAGES(SYNC_STAGES), .CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(clk), .reset(reset), .i_raw(btn_step_raw), .o_db(w_db_step)
    );
    sync_debounce #(.STAGES(SYNC_STAGES), .CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .reset(reset), .i_raw(sw_mode_raw), .o_db(w_db_mode)
    );
    sync_debounce #(.STAGES(SYNC_STAGES), .CYCLES(DEBOUNCE_CYCLES)) u_db_fast (
        .clk(clk), .reset(reset), .i_raw(sw_fast_raw), .o_db(w_db_fast)
    );

    assign setFreq      = w_db_fast;
    assign w_step_pulse = w_db_step & ~r_step_prev;
    // Stretch reloads on the debounced release so sys_reset holds through the fall cycle.
    assign w_stretch_nxt = (r_rst_prev & ~w_db_rst) ? SW'(RESET_STRETCH) :
                           (r_stretch != '0) ? r_stretch - 1'b1 : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RC_RUN:       if (w_db_mode || r_latch) w_state_nxt = RC_HALTED;
            RC_HALTED:    if (!r_latch) w_state_nxt = !w_db_mode ? RC_RUN :
                                                      w_step_pulse ? RC_STEP_LOW : RC_HALTED;
            RC_STEP_LOW:  if (!reg1Hz) w_state_nxt = RC_STEP_HIGH;
            RC_STEP_HIGH: if (reg1Hz) w_state_nxt = RC_HALTED;
            default:      w_state_nxt = RC_HALTED;
        endcase
        if (sys_reset) w_state_nxt = RC_HALTED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sys_reset   <= 1'b1;
            halt        <= 1'b1;
            step_busy   <= 1'b0;
            r_state     <= RC_HALTED;
            r_latch     <= 1'b0;
            r_stretch   <= '0;
            r_rst_prev  <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            sys_reset   <= w_db_rst | (w_stretch_nxt != '0);
            halt        <= r_state == RC_HALTED || r_state == RC_STEP_HIGH;
            step_busy   <= r_state == RC_STEP_LOW || r_state == RC_STEP_HIGH;
            r_state     <= w_state_nxt;
            r_latch     <= sys_reset ? 1'b0 : r_latch | cpu_halt;
            r_stretch   <= w_stretch_nxt;
            r_rst_prev  <= w_db_rst;
            r_step_prev <= w_db_step;
        end
    end

`ifdef RUN_CONTROL_STEP_COUNT_EN
    logic [15:0] r_step_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step_count <= '0;
        end else if (sys_reset) begin
            r_step_count <= '0;
        end else if (r_state == RC_STEP_HIGH && w_state_nxt == RC_HALTED) begin
            r_step_count <= r_step_count + 16'd1;
        end
    end

    assign step_count = r_step_count;
`endif

endmodule

// File: tb/tb_run_control.sv
// tb_run_control: per-cycle timeline scenarios for run_control with
// DEBOUNCE_CYCLES=4, SYNC_STAGES=2, RESET_STRETCH=3 (raw edge -> debounced in 6 edges).
module tb_run_control;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_reset_raw = 1'b0, btn_step_raw = 1'b0, sw_mode_raw = 1'b0, sw_fast_raw = 1'b0;
    logic cpu_halt = 1'b0, reg1Hz = 1'b1;
    logic sys_reset, setFreq, halt, step_busy;
`ifdef RUN_CONTROL_STEP_COUNT_EN
    logic [15:0] step_count;
`endif
    logic [3:0] got;
    logic [3:0] exp_q[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // Observed vector: {sys_reset, halt, step_busy, setFreq}
    assign got = {sys_reset, halt, step_busy, setFreq};

    run_control #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .RESET_STRETCH(3)) dut (
        .clk(clk), .reset(reset),
        .btn_reset_raw(btn_reset_raw), .btn_step_raw(btn_step_raw),
        .sw_mode_raw(sw_mode_raw), .sw_fast_raw(sw_fast_raw),
        .cpu_halt(cpu_halt), .reg1Hz(reg1Hz),
        .sys_reset(sys_reset), .setFreq(setFreq), .halt(halt), .step_busy(step_busy)
`ifdef RUN_CONTROL_STEP_COUNT_EN
        , .step_count(step_count)
`endif
    );

    task automatic test_reset();
        logic [3:0] e;
        repeat (2) @(negedge clk);
        total++;
        if (got !== 4'b1100) begin
            bad++;
            $display("FAIL reset_vals got=%b exp=1100", got);
        end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back({1'b0, k <= 2, 1'b0, 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset_release k=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_run_halt();
        logic [3:0] e;
        for (int k = 1; k <= 18; k++) begin
            sw_fast_raw = k <= 10;
            cpu_halt = k == 2;
            exp_q.push_back({1'b0, k >= 4, 1'b0, k >= 6 && k <= 15});
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL run_halt k=%0d got=%b exp=%b", k, got, e);
            end
        end
        cpu_halt = 1'b0;
    endtask

    task automatic test_stretch();
        logic [3:0] e;
        for (int k = 1; k <= 24; k++) begin
            btn_reset_raw = k <= 10;
            exp_q.push_back({k >= 7 && k <= 19, k <= 21, 1'b0, 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL stretch k=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] e;
        for (int k = 1; k <= 8; k++) begin
            sw_fast_raw = 1'b1;
            exp_q.push_back({1'b0, 1'b0, 1'b0, k >= 6});
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL pre_async k=%0d got=%b exp=%b", k, got, e);
            end
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (got !== 4'b1100) begin
            bad++;
            $display("FAIL async_immediate got=%b exp=1100", got);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            sw_fast_raw = k <= 8;
            exp_q.push_back({1'b0, k <= 2, 1'b0, k >= 6 && k <= 13});
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL async_release k=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] e;
        for (int k = 1; k <= 45; k++) begin
            sw_mode_raw = 1'b1;
            btn_step_raw = k == 11 || k == 12 || k == 15 || k == 16 || (k >= 25 && k <= 30);
            reg1Hz = !(k >= 35 && k <= 36);
            exp_q.push_back({1'b0, !(k < 8 || (k >= 32 && k <= 35)), k >= 32 && k <= 37, 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL bounce k=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_single_step();
        logic [3:0] e;
        for (int k = 1; k <= 34; k++) begin
            btn_step_raw = k <= 6 || (k >= 14 && k <= 19);
            reg1Hz = !(k >= 22 && k <= 25);
            exp_q.push_back({1'b0, !(k >= 8 && k <= 22), k >= 8 && k <= 26, 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL single_step k=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

    task automatic test_mode_during_step();
        logic [3:0] e;
        for (int k = 1; k <= 22; k++) begin
            btn_step_raw = k <= 6;
            sw_mode_raw = k < 9;
            reg1Hz = !(k >= 16 && k <= 17);
            exp_q.push_back({1'b0, !((k >= 8 && k <= 16) || k >= 20), k >= 8 && k <= 18, 1'b0});
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL mode_during_step k=%0d got=%b exp=%b", k, got, e);
            end
        end
    endtask

`ifdef RUN_CONTROL_STEP_COUNT_EN
    task automatic test_step_count();
        total++;
        if (step_count !== 16'd3) begin
            bad++;
            $display("FAIL step_count_three got=%0d exp=3", step_count);
        end
        sw_mode_raw = 1'b1;
        repeat (10) @(negedge clk);
        dut.r_step_count = 16'hFFFE;
        for (int s = 0; s < 2; s++) begin
            btn_step_raw = 1'b1;
            repeat (6) @(negedge clk);
            btn_step_raw = 1'b0;
            repeat (2) @(negedge clk);
            reg1Hz = 1'b0;
            repeat (2) @(negedge clk);
            reg1Hz = 1'b1;
            repeat (10) @(negedge clk);
        end
        total++;
        if (step_count !== 16'd0) begin
            bad++;
            $display("FAIL step_count_wrap got=%0d exp=0", step_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_run_halt();
        test_stretch();
        test_async_reset();
        test_bounce();
        test_single_step();
        test_mode_during_step();
`ifdef RUN_CONTROL_STEP_COUNT_EN
        test_step_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_control.md
# run_control

Front-panel run/step controller that sits directly upstream of the clock-enable frequency divider. It synchronizes and debounces the raw board buttons and switches, then produces the divider's `reset`, `setFreq` and `halt` inputs. It closes a loop on the divider's `reg1Hz` output so that a single-step press advances the processor by exactly one slow-clock period. It also latches halt requests raised by the datapath, for example a halt instruction.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles needed to accept an input change (20 ms at 25 MHz).
- `SYNC_STAGES`, default 2: synchronizer flops per raw input; minimum 2.
- `RESET_STRETCH`, default 16: cycles `sys_reset` stays high after the reset button is released.

Ports (one clock; `reset` is asynchronous and active-high):
- `clk`  in  1  system clock; same clock as the divider.
- `reset`  in  1  asynchronous, active-high global reset.
- `btn_reset_raw`  in  1  raw reset push-button, active-high.
- `btn_step_raw`  in  1  raw step push-button, active-high.
- `sw_mode_raw`  in  1  raw mode switch; 1 = step mode, 0 = run mode.
- `sw_fast_raw`  in  1  raw speed switch; 1 = fast.
- `cpu_halt`  in  1  one-cycle or level halt request from the datapath.
- `reg1Hz`  in  1  divider output, fed back; same clock domain, no synchronizer.
- `sys_reset`  out  1  drives the divider's and the CPU's `reset`.
- `setFreq`  out  1  debounced `sw_fast`; drives the divider's `setFreq`.
- `halt`  out  1  drives the divider's `halt`.
- `step_busy`  out  1  high while a single step is in progress.

## Operation
- **Input conditioning.** Each raw input passes through a `SYNC_STAGES`-deep synchronizer and then a debouncer.
  - Debouncer counter clears whenever the synced value equals the accepted value.
  - Otherwise it increments; when it reaches `DEBOUNCE_CYCLES - 1`, the accepted value flips and the counter clears.
- **Step pulse.** `step_pulse` is a one-cycle pulse on the rising edge of the debounced step button.
- **Reset button.** `sys_reset` = `reset` OR debounced reset button OR a stretch counter still running.
  - The stretch counter loads `RESET_STRETCH` on a falling edge of the debounced reset button and counts down to 0.
- **Halt latch.**
  - Sets on `cpu_halt`=1.
  - Clears only while `sys_reset`=1.
  - `cpu_halt` takes effect the cycle after it is sampled.
- **FSM states:** RUN, HALTED, STEP_LOW, STEP_HIGH.
  - RUN: `halt`=0. Goes to HALTED if the mode is step or the halt latch is set.
  - HALTED: `halt`=1.
    - Goes to RUN if the mode is run and the latch is clear.
    - Goes to STEP_LOW if the mode is step, `step_pulse`=1 and the latch is clear.
  - STEP_LOW: `halt`=0, `step_busy`=1. Goes to STEP_HIGH when `reg1Hz`=0.
  - STEP_HIGH: `halt`=1, `step_busy`=1. The divider keeps counting while `reg1Hz` is low. Goes to HALTED when `reg1Hz`=1.
- **Boundary conditions.**
  - Step presses during STEP_LOW/STEP_HIGH are dropped, not queued.
  - A mode change to run during a step takes effect only after the step returns to HALTED.
  - The halt latch setting during a step does not abort the step; the next state is HALTED.
  - `sys_reset` high forces HALTED synchronously and clears the latch. It does not reset the debouncers.
  - `step_pulse` and the mode change in the same cycle: the mode is evaluated from its debounced value in that same cycle.

## Timing
- **Reset values:** `sys_reset`=1, `setFreq`=0, `halt`=1, `step_busy`=0, FSM=HALTED. Debouncer accepted values=0, counters=0, stretch counter=0.
- **Input latency:** a clean raw edge reaches its debounced output after `SYNC_STAGES + DEBOUNCE_CYCLES` cycles.
- **Output registers:** all outputs are registered, so an FSM transition is visible on `halt` one cycle later.
- **`sys_reset` release:** deasserts exactly `RESET_STRETCH` cycles after the debounced reset button falls. With `RESET_STRETCH`=0 it deasserts on the next cycle.
- **Step length:** one step lasts from the entry to STEP_LOW until the first cycle with `reg1Hz`=1 after `reg1Hz` was seen low. That is one full divider period.

## Configuration
- **`RUN_CONTROL_STEP_COUNT_EN` defined:** adds output port `step_count` (out, 16 bits).
  - Increments on each STEP_HIGH→HALTED transition.
  - Wraps from 0xFFFF to 0.
  - Clears on `sys_reset`.
- **Undefined:** the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `run_control_pkg` holds:
  - the FSM state enum (`RC_RUN`, `RC_HALTED`, `RC_STEP_LOW`, `RC_STEP_HIGH`);
  - the default constants `RC_DEBOUNCE_DEFAULT` and `RC_RESET_STRETCH_DEFAULT`.
- One sub-module, `sync_debounce`: parameterized synchronizer plus debouncer for a single bit, instantiated four times.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2, `RESET_STRETCH`=3.
1. **Reset values:** assert `reset` mid-run → all outputs take reset values immediately (asynchronous); release → `sys_reset` falls next cycle, FSM stays HALTED.
2. **Bounce rejection:** toggle `btn_step_raw` 1-0-1-0 at 2-cycle spacing → no `step_pulse`. Hold it 1 for 6 cycles → exactly one STEP_LOW entry at cycle 2+4.
3. **Single step:** step mode with a divider model, `reg1Hz`=1 → `halt` low until `reg1Hz`=0, high after, HALTED when `reg1Hz` returns to 1. A second press during `step_busy` is ignored.
4. **Run and halt instruction:** mode=run → `halt`=0. `cpu_halt` pulse → `halt`=1 two cycles later and stays high until a reset button press.
5. **Reset stretch:** press and then release `btn_reset_raw` → `sys_reset` high through debounce and for 3 cycles after the debounced release; FSM is HALTED on release.
6. **Step counter (with `RUN_CONTROL_STEP_COUNT_EN`):** 3 steps → `step_count`=3. Preload near 0xFFFF and step twice → wraps to 0.
